// File: rtl/multdiv_pkg.sv
// Shared definitions for the multiply/divide unit.
//   state_t       : controller state encoding (IDLE, MULT, DIV, DONE)
//   DEFAULT_WIDTH : default operand/result width
package multdiv_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/multdiv_iter_counter.sv
// Iteration down-counter for the multiply/divide unit.
// Ports:
//   clock    : rising-edge clock
//   reset    : asynchronous active-low reset, clears the count to 0
//   load     : load load_val (takes precedence over dec)
//   load_val : iteration count for the accepted operation
//   dec      : decrement by one; saturates at 0 so it never wraps
//   tc       : terminal count, high while the final iteration is executing
module multdiv_iter_counter #(
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             tc
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign tc = (count == CNT_W'(1));

endmodule

// File: rtl/multdiv_unit.sv
// Sequential signed multiply / divide unit.
// Multiply is Booth-encoded (radix-2, one bit per cycle); divide is restoring
// division on magnitudes (one quotient bit per cycle) with the sign fixed up
// on the final iteration.
// Optional feature macro: MULTDIV_BOOTH4_EN selects radix-4 Booth multiply
// (two multiplier bits per cycle, WIDTH must be even). Divide is unaffected.
// Ports:
//   clock, reset        : rising-edge clock, asynchronous active-low reset
//   ctrl_MULT, ctrl_DIV : start strobes, sampled only in IDLE/DONE (MULT wins)
//   data_operandA/B     : multiplicand/dividend and multiplier/divisor
//   data_result         : product low half or quotient, held until next result
//   data_exception      : multiply overflow, divide-by-zero or divide overflow
//   data_resultRDY      : one-cycle pulse when result/exception are new
//   busy                : high while an operation is iterating
//
// state | meaning
// IDLE  | waiting for a start
// MULT  | Booth iterations in progress
// DIV   | divide iterations in progress (first cycle also catches divisor 0)
// DONE  | result-ready cycle; a new start is accepted here too
module multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);
`ifdef MULTDIV_BOOTH4_EN
    localparam int ACC_W      = WIDTH + 2;
    localparam int MULT_ITERS = WIDTH / 2;
`else
    localparam int ACC_W      = WIDTH + 1;
    localparam int MULT_ITERS = WIDTH;
`endif
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_ITERS);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(WIDTH);
    localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    state_t state, state_nxt;

    // hi: Booth accumulator or partial remainder
    // lo: multiplier shifting out / dividend shifting out, quotient shifting in
    // op_b: multiplicand or divisor magnitude
    logic [ACC_W-1:0] hi;
    logic [WIDTH-1:0] lo, op_b;
    logic             q_1;
    logic             neg_q, div_ovf;
    logic [WIDTH-1:0] result_q;
    logic             exc_q;

    logic accept, accept_mult, iterating, iter_tc, div_zero;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign accept      = ((state == IDLE) || (state == DONE)) && (ctrl_MULT || ctrl_DIV);
    assign accept_mult = accept && ctrl_MULT;
    assign iterating   = (state == MULT) || (state == DIV);
    assign div_zero    = (op_b == '0);
    assign a_mag       = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign b_mag       = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    multdiv_iter_counter #(
        .CNT_W (CNT_W)
    ) u_iter (
        .clock    (clock),
        .reset    (reset),
        .load     (accept),
        .load_val (accept_mult ? MULT_LOAD : DIV_LOAD),
        .dec      (iterating),
        .tc       (iter_tc)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (ctrl_MULT) begin
                    state_nxt = MULT;
                end else if (ctrl_DIV) begin
                    state_nxt = DIV;
                end else begin
                    state_nxt = IDLE;
                end
            end
            MULT:    if (iter_tc) state_nxt = DONE;
            DIV:     if (div_zero || iter_tc) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // Booth step
    logic [ACC_W-1:0] mcand_ext, booth_sum, hi_mul_nxt;
    logic [WIDTH-1:0] lo_mul_nxt;
    logic             q_1_mul_nxt, mul_ovf;

    assign mcand_ext = {{(ACC_W-WIDTH){op_b[WIDTH-1]}}, op_b};

    always_comb begin
        booth_sum = hi;
`ifdef MULTDIV_BOOTH4_EN
        case ({lo[1:0], q_1})
            3'b001, 3'b010: booth_sum = hi + mcand_ext;
            3'b011:         booth_sum = hi + (mcand_ext << 1);
            3'b100:         booth_sum = hi - (mcand_ext << 1);
            3'b101, 3'b110: booth_sum = hi - mcand_ext;
            default:        booth_sum = hi;
        endcase
        hi_mul_nxt  = {{2{booth_sum[ACC_W-1]}}, booth_sum[ACC_W-1:2]};
        lo_mul_nxt  = {booth_sum[1:0], lo[WIDTH-1:2]};
        q_1_mul_nxt = lo[1];
`else
        case ({lo[0], q_1})
            2'b01:   booth_sum = hi + mcand_ext;
            2'b10:   booth_sum = hi - mcand_ext;
            default: booth_sum = hi;
        endcase
        hi_mul_nxt  = {booth_sum[ACC_W-1], booth_sum[ACC_W-1:1]};
        lo_mul_nxt  = {booth_sum[0], lo[WIDTH-1:1]};
        q_1_mul_nxt = lo[0];
`endif
    end

    // Product high half must be pure sign extension of the low half.
    assign mul_ovf = (hi_mul_nxt[WIDTH-1:0] != {WIDTH{lo_mul_nxt[WIDTH-1]}});

    // Restoring divide step. The shifted remainder is below 2*divisor, so the
    // WIDTH+1 bit difference carries a valid sign.
    logic [WIDTH:0]   div_shift, div_trial, rem_nxt;
    logic [WIDTH-1:0] lo_div_nxt, quot_final;

    assign div_shift  = {hi[WIDTH-1:0], lo[WIDTH-1]};
    assign div_trial  = div_shift - {1'b0, op_b};
    assign rem_nxt    = div_trial[WIDTH] ? div_shift : div_trial;
    assign lo_div_nxt = {lo[WIDTH-2:0], ~div_trial[WIDTH]};
    assign quot_final = neg_q ? -lo_div_nxt : lo_div_nxt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hi       <= '0;
            lo       <= '0;
            op_b     <= '0;
            q_1      <= 1'b0;
            neg_q    <= 1'b0;
            div_ovf  <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (ctrl_MULT) begin
                        hi   <= '0;
                        lo   <= data_operandB;
                        op_b <= data_operandA;
                        q_1  <= 1'b0;
                    end else if (ctrl_DIV) begin
                        hi      <= '0;
                        lo      <= a_mag;
                        op_b    <= b_mag;
                        neg_q   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                        div_ovf <= (data_operandA == MOST_NEG) && (data_operandB == '1);
                    end
                end
                MULT: begin
                    hi  <= hi_mul_nxt;
                    lo  <= lo_mul_nxt;
                    q_1 <= q_1_mul_nxt;
                    if (iter_tc) begin
                        result_q <= lo_mul_nxt;
                        exc_q    <= mul_ovf;
                    end
                end
                DIV: begin
                    if (div_zero) begin
                        result_q <= '0;
                        exc_q    <= 1'b1;
                    end else begin
                        hi <= ACC_W'(rem_nxt);
                        lo <= lo_div_nxt;
                        if (iter_tc) begin
                            result_q <= quot_final;
                            exc_q    <= div_ovf;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = (state == DONE);
    assign busy           = iterating;

endmodule
